// File: rtl/foo_result_collector.sv
// -----------------------------------------------------------------------------
// foo_result_collector
//
// Downstream stage of the two-lane foo array. Each cycle's lane result pair
// (x0, x1) is buffered in a DEPTH-entry FIFO when in_valid is high and the
// FIFO is not full; otherwise the pair is dropped and counted. Stored pairs are
// serialised onto one WIDTH-bit valid/ready stream, lane 0 first, then lane 1.
// A running checksum (mod 2^WIDTH) of all accepted words is maintained.
//
// Ports:
//   clk        in   sole clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset, priority over all events
//   in_valid   in   x0/x1 carry a result pair this cycle
//   x0, x1     in   lane 0 / lane 1 results (WIDTH)
//   out_valid  out  out_data holds a valid word (== !empty)
//   out_ready  in   consumer accepts out_data this cycle
//   out_data   out  serialised result word (WIDTH)
//   out_lane   out  lane index of out_data
//   level      out  number of stored pairs ($clog2(DEPTH)+1 bits)
//   full       out  level == DEPTH
//   empty      out  level == 0
//   drop_count out  pairs dropped while full, saturating (CNT_W)
//   checksum   out  running sum of accepted words, mod 2^WIDTH
// -----------------------------------------------------------------------------
module foo_result_collector #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         x0,
    input  logic [WIDTH-1:0]         x1,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_lane,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic [CNT_W-1:0]         drop_count,
    output logic [WIDTH-1:0]         checksum
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic {
        LANE0 = 1'b0,
        LANE1 = 1'b1
    } phase_e;

    // Pair storage; lane arrays share the same pointers.
    logic [WIDTH-1:0] mem0_q [DEPTH];
    logic [WIDTH-1:0] mem1_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             out_valid_q, out_valid_d;
    phase_e           phase_q, phase_d;
    logic [CNT_W-1:0] drop_count_q, drop_count_d;
    logic [WIDTH-1:0] checksum_q, checksum_d;

    logic push;
    logic drop;
    logic handshake;
    logic pop;

    always_comb begin
        // Admission uses the registered full flag, so a pop in the same cycle
        // as an arriving pair never frees space for it.
        push      = in_valid && !full_q;
        drop      = in_valid && full_q;
        handshake = out_valid_q && out_ready;
        pop       = handshake && (phase_q == LANE1);

        wr_ptr_d = wr_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        phase_d = phase_q;
        if (handshake) begin
            phase_d = (phase_q == LANE0) ? LANE1 : LANE0;
        end

        drop_count_d = drop_count_q;
        if (drop && (drop_count_q != '1)) begin
            drop_count_d = drop_count_q + CNT_W'(1);
        end

        checksum_d = checksum_q;
        if (push) begin
            checksum_d = checksum_q + x0 + x1;
        end

        // Status flags are registered from the next level so they line up
        // with level_q without a decode after the flop.
        full_d      = (level_d == LVL_W'(DEPTH));
        empty_d     = (level_d == '0);
        out_valid_d = (level_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            out_valid_q  <= 1'b0;
            phase_q      <= LANE0;
            drop_count_q <= '0;
            checksum_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            out_valid_q  <= out_valid_d;
            phase_q      <= phase_d;
            drop_count_q <= drop_count_d;
            checksum_q   <= checksum_d;
        end
    end

    // Payload storage needs no reset: it is only observed while level > 0.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem0_q[wr_ptr_q] <= x0;
            mem1_q[wr_ptr_q] <= x1;
        end
    end

    always_comb begin
        out_valid  = out_valid_q;
        out_lane   = (phase_q == LANE1);
        out_data   = (phase_q == LANE1) ? mem1_q[rd_ptr_q] : mem0_q[rd_ptr_q];
        level      = level_q;
        full       = full_q;
        empty      = empty_q;
        drop_count = drop_count_q;
        checksum   = checksum_q;
    end

endmodule

// File: tb/tb_foo_result_collector.sv
module tb_foo_result_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] x0, x1;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_lane;
    logic [3:0]  level;
    logic        full, empty;
    logic [15:0] drop_count;
    logic [31:0] checksum;

    // Small instance for the saturation boundary of the drop counter.
    logic        in_valid_s;
    logic [31:0] x0_s, x1_s;
    logic        out_valid_s, out_ready_s, out_lane_s, full_s, empty_s;
    logic [31:0] out_data_s, checksum_s;
    logic [1:0]  level_s;
    logic [3:0]  drop_count_s;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [32:0] exp_q[$];
    logic [31:0] exp_ck;
    int          exp_drop;

    logic        prev_hold = 1'b0;
    logic [31:0] prev_data;
    logic        prev_lane;
    logic [32:0] mon_e;

    always #5 clk = ~clk;

    foo_result_collector #(.WIDTH(32), .DEPTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .x0(x0), .x1(x1),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_lane(out_lane), .level(level), .full(full), .empty(empty),
        .drop_count(drop_count), .checksum(checksum)
    );

    foo_result_collector #(.WIDTH(32), .DEPTH(2), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid_s), .x0(x0_s), .x1(x1_s),
        .out_valid(out_valid_s), .out_ready(out_ready_s), .out_data(out_data_s),
        .out_lane(out_lane_s), .level(level_s), .full(full_s), .empty(empty_s),
        .drop_count(drop_count_s), .checksum(checksum_s)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input bit accept);
        in_valid = 1'b1;
        x0 = a;
        x1 = b;
        if (accept) begin
            exp_q.push_back({1'b0, a});
            exp_q.push_back({1'b1, b});
            exp_ck = exp_ck + a + b;
        end else begin
            exp_drop++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int max_cyc, input bit toggle);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            if (toggle) out_ready = ~out_ready;
            else        out_ready = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        out_ready = 1'b0;
        chk({name, "_left"}, 64'(exp_q.size()), 64'd0);
        chk({name, "_empty"}, 64'(empty), 64'd1);
        chk({name, "_level"}, 64'(level), 64'd0);
    endtask

    // Monitor: compares every accepted word against the scoreboard and checks
    // that a stalled word does not change.
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else if (out_valid) begin
            if (prev_hold) begin
                n_cmp++;
                if (out_data !== prev_data || out_lane !== prev_lane) begin
                    n_fail++;
                    $display("FAIL hold_stable: got lane%0d 0x%0h expected lane%0d 0x%0h",
                             out_lane, out_data, prev_lane, prev_data);
                end
            end
            if (out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stream_extra: got lane%0d 0x%0h expected no word",
                             out_lane, out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({out_lane, out_data} !== mon_e) begin
                        n_fail++;
                        $display("FAIL stream_word: got lane%0d 0x%0h expected lane%0d 0x%0h",
                                 out_lane, out_data, mon_e[32], mon_e[31:0]);
                    end
                end
            end
            prev_hold = !out_ready;
            prev_data = out_data;
            prev_lane = out_lane;
        end else begin
            prev_hold = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; x0 = '0; x1 = '0; out_ready = 1'b0;
        in_valid_s = 1'b0; x0_s = '0; x1_s = '0; out_ready_s = 1'b0;
        exp_ck = '0; exp_drop = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_lane", 64'(out_lane), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_drop", 64'(drop_count), 64'd0);
        chk("rst_checksum", 64'(checksum), 64'd0);
        rst = 1'b0;

        // Single pair, lane 0 visible the cycle after the push.
        out_ready = 1'b1;
        push(32'h11, 32'h22, 1'b1);
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_lane", 64'(out_lane), 64'd0);
        chk("t1_data", 64'(out_data), 64'h11);
        repeat (2) @(posedge clk);
        #1;
        chk("t1_empty", 64'(empty), 64'd1);
        chk("t1_checksum", 64'(checksum), 64'h33);

        // Ten back-to-back pushes into a stalled FIFO: two drops.
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) push(32'h100 + i, 32'h200 + i, i < 8);
        chk("t2_level", 64'(level), 64'd8);
        chk("t2_full", 64'(full), 64'd1);
        chk("t2_drop", 64'(drop_count), 64'd2);
        chk("t2_checksum", 64'(checksum), 64'(exp_ck));
        drain("t2_drain", 40, 1'b0);

        // Toggling backpressure.
        for (int i = 0; i < 3; i++) push(32'hB0 + i, 32'hC0 + i, 1'b1);
        drain("t3_drain", 40, 1'b1);

        // Full FIFO: arriving pair collides with the final lane-1 handshake.
        for (int i = 0; i < 8; i++) push(32'hD0 + i, 32'hE0 + i, 1'b1);
        chk("t4_full", 64'(full), 64'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b1; x0 = 32'hDEAD; x1 = 32'hBEEF;
        exp_drop++;
        @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b0;
        chk("t4_level", 64'(level), 64'd7);
        chk("t4_full", 64'(full), 64'd0);
        chk("t4_drop", 64'(drop_count), 64'd3);
        chk("t4_drop_model", 64'(drop_count), 64'(exp_drop));
        chk("t4_checksum", 64'(checksum), 64'(exp_ck));
        drain("t4_drain", 40, 1'b0);

        // Reset in the middle of a half-sent pair.
        for (int i = 0; i < 5; i++) push(32'h50 + i, 32'h60 + i, 1'b1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_ck = '0;
        exp_drop = 0;
        chk("t5_valid", 64'(out_valid), 64'd0);
        chk("t5_level", 64'(level), 64'd0);
        chk("t5_drop", 64'(drop_count), 64'd0);
        chk("t5_checksum", 64'(checksum), 64'd0);
        chk("t5_lane", 64'(out_lane), 64'd0);
        out_ready = 1'b1;
        push(32'hA5, 32'h5A, 1'b1);
        chk("t5_new_lane", 64'(out_lane), 64'd0);
        chk("t5_new_data", 64'(out_data), 64'hA5);
        drain("t5_drain", 10, 1'b0);

        // Wrap-around with interleaved drain, values chosen to overflow the sum.
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            push(32'hF000_0000 + 32'(i) * 32'h0123_4567, 32'h9000_0000 + 32'(i) * 32'h1111, 1'b1);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        drain("t6_drain", 20, 1'b0);
        chk("t6_drop", 64'(drop_count), 64'd0);
        chk("t6_checksum", 64'(checksum), 64'(exp_ck));

        // Saturation on the 4-bit counter instance: 2 accepted, then drops.
        in_valid_s = 1'b1; x0_s = 32'h1; x1_s = 32'h2;
        repeat (16) @(posedge clk);
        #1;
        chk("t7_drop_14", 64'(drop_count_s), 64'd14);
        repeat (1) @(posedge clk);
        #1;
        chk("t7_drop_15", 64'(drop_count_s), 64'd15);
        repeat (5) @(posedge clk);
        #1;
        in_valid_s = 1'b0;
        chk("t7_drop_sat", 64'(drop_count_s), 64'd15);
        chk("t7_level", 64'(level_s), 64'd2);
        chk("t7_checksum", 64'(checksum_s), 64'd6);

        repeat (3) @(posedge clk);
        #1;
        chk("final_left", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
